// File: rtl/pipelined_addsub.sv
// Segmented, pipelined add/subtract unit with carry/borrow-in, overflow detection,
// optional saturation and valid/ready flow control; latency equals the segment count.
module pipelined_addsub #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op_sub,
  input  logic             op_signed,
  input  logic             op_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int STAGES = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam int LAST   = STAGES - 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  // Per-stage state: operands skew forward, lower result segments are carried along.
  logic [STAGES-1:0] vld_q, vld_d, ld;
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  r_q   [STAGES];
  logic              c_q   [STAGES];
  logic              sub_q [STAGES];
  logic              sgn_q [STAGES];
  logic              sat_q [STAGES];

  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [WIDTH-1:0]  r_d   [STAGES];
  logic              c_d   [STAGES];
  logic              sub_d [STAGES];
  logic              sgn_d [STAGES];
  logic              sat_d [STAGES];
  logic [WIDTH-1:0]  rin   [STAGES];
  logic              ci    [STAGES];
  logic [WIDTH-1:0]  rip   [STAGES];

  logic rdy_q, rdy_d;
  logic ovf_q, ovf_d;

  // Load enables: a stage advances if it or any stage downstream of it frees up.
  always_comb begin
    logic free;
    ld   = '0;
    free = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      free  = free | ~vld_q[k];
      ld[k] = free;
    end
  end

  assign in_ready = rdy_q & ld[0];

  // Stage inputs: stage 0 takes the ports, every other stage its predecessor's registers.
  always_comb begin
    int prv;
    prv   = 0;
    rdy_d = 1'b1;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        a_d[k]   = a;
        b_d[k]   = op_sub ? ~b : b;
        rin[k]   = '0;
        ci[k]    = op_sub ? ~cin : cin;
        sub_d[k] = op_sub;
        sgn_d[k] = op_signed;
        sat_d[k] = op_sat;
        vld_d[k] = in_valid & in_ready;
      end else begin
        prv      = k - 1;
        a_d[k]   = a_q[prv];
        b_d[k]   = b_q[prv];
        rin[k]   = r_q[prv];
        ci[k]    = c_q[prv];
        sub_d[k] = sub_q[prv];
        sgn_d[k] = sgn_q[prv];
        sat_d[k] = sat_q[prv];
        vld_d[k] = vld_q[prv];
      end
    end
  end

  // Ripple-carry over the segment owned by each stage; bits above WIDTH-1 simply do not exist.
  always_comb begin
    logic carry;
    carry = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      carry  = ci[k];
      rip[k] = rin[k];
      for (int i = 0; i < WIDTH; i++) begin
        if ((i >= k * SEG_WIDTH) && (i < (k + 1) * SEG_WIDTH)) begin
          rip[k][i] = a_d[k][i] ^ b_d[k][i] ^ carry;
          carry     = (a_d[k][i] & b_d[k][i]) | (carry & (a_d[k][i] ^ b_d[k][i]));
        end else begin
          rip[k][i] = rin[k][i];
        end
      end
      c_d[k] = carry;
    end
  end

  // Overflow is judged on the unsaturated result; only the final stage clamps.
  always_comb begin
    logic a_msb, b_msb, r_msb;
    for (int k = 0; k < STAGES; k++) begin
      r_d[k] = rip[k];
    end
    a_msb = a_d[LAST][WIDTH-1];
    b_msb = b_d[LAST][WIDTH-1];
    r_msb = rip[LAST][WIDTH-1];
    if (sgn_d[LAST]) begin
      ovf_d = (a_msb == b_msb) && (r_msb != a_msb);
    end else if (sub_d[LAST]) begin
      ovf_d = ~c_d[LAST];
    end else begin
      ovf_d = c_d[LAST];
    end
    if (sat_d[LAST] && ovf_d) begin
      if (sgn_d[LAST]) begin
        r_d[LAST] = a_msb ? SMIN : SMAX;
      end else if (sub_d[LAST]) begin
        r_d[LAST] = '0;
      end else begin
        r_d[LAST] = '1;
      end
    end else begin
      r_d[LAST] = rip[LAST];
    end
  end

  // Pipeline registers; data only moves when a valid transaction enters the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      rdy_q <= 1'b0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        r_q[k]   <= '0;
        c_q[k]   <= 1'b0;
        sub_q[k] <= 1'b0;
        sgn_q[k] <= 1'b0;
        sat_q[k] <= 1'b0;
      end
    end else begin
      rdy_q <= rdy_d;
      for (int k = 0; k < STAGES; k++) begin
        if (ld[k]) begin
          vld_q[k] <= vld_d[k];
          if (vld_d[k]) begin
            a_q[k]   <= a_d[k];
            b_q[k]   <= b_d[k];
            r_q[k]   <= r_d[k];
            c_q[k]   <= c_d[k];
            sub_q[k] <= sub_d[k];
            sgn_q[k] <= sgn_d[k];
            sat_q[k] <= sat_d[k];
          end
        end
      end
      if (ld[LAST] && vld_d[LAST]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign out_valid = vld_q[LAST];
  assign sum       = r_q[LAST];
  assign cout      = c_q[LAST];
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and scoreboarded bench for pipelined_addsub in three geometries:
// 32/8 (four stages), 12/8 (partial top segment) and 32/32 (single stage).
module tb_pipelined_addsub;

  logic        clk;
  logic        rst_n;
  logic [2:0]  in_valid_v;
  wire  [2:0]  in_ready_v;
  wire  [2:0]  out_valid_v;
  wire  [2:0]  cout_v;
  wire  [2:0]  ovf_v;
  logic [31:0] a, b;
  logic        cin, op_sub, op_signed, op_sat, out_ready;
  wire  [31:0] sum0, sum2;
  wire  [11:0] sum1;

  int n_chk = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb[$];

  pipelined_addsub #(.WIDTH(32), .SEG_WIDTH(8)) u_w32s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub), .op_signed(op_signed), .op_sat(op_sat),
    .out_valid(out_valid_v[0]), .out_ready(out_ready), .sum(sum0), .cout(cout_v[0]),
    .overflow(ovf_v[0]));

  pipelined_addsub #(.WIDTH(12), .SEG_WIDTH(8)) u_w12s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .a(a[11:0]), .b(b[11:0]), .cin(cin), .op_sub(op_sub), .op_signed(op_signed), .op_sat(op_sat),
    .out_valid(out_valid_v[1]), .out_ready(out_ready), .sum(sum1), .cout(cout_v[1]),
    .overflow(ovf_v[1]));

  pipelined_addsub #(.WIDTH(32), .SEG_WIDTH(32)) u_w32s32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub), .op_signed(op_signed), .op_sat(op_sat),
    .out_valid(out_valid_v[2]), .out_ready(out_ready), .sum(sum2), .cout(cout_v[2]),
    .overflow(ovf_v[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_sum(input int d);
    case (d)
      0:       return sum0;
      1:       return {20'd0, sum1};
      default: return sum2;
    endcase
  endfunction

  // Integer reference for the 32-bit unit.
  function automatic exp_t ref_model(input logic [31:0] xa, xb, input logic xcin, xsub, xsgn, xsat);
    longint ua, ub, sa, sb_, t, st, c;
    exp_t   e;
    ua = {32'd0, xa};
    ub = {32'd0, xb};
    sa = longint'($signed(xa));
    sb_ = longint'($signed(xb));
    c  = {63'd0, xcin};
    if (xsub) begin
      t    = ua - ub - c;
      st   = sa - sb_ - c;
      e.co = (t >= 64'sd0);
    end else begin
      t    = ua + ub + c;
      st   = sa + sb_ + c;
      e.co = (t > 64'sd4294967295);
    end
    if (xsgn) e.ov = (st > 64'sd2147483647) || (st < -64'sd2147483648);
    else      e.ov = xsub ? !e.co : e.co;
    if (xsat && e.ov) begin
      if (xsgn)      e.s = xa[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else if (xsub) e.s = 32'h0000_0000;
      else           e.s = 32'hFFFF_FFFF;
    end else begin
      e.s = t[31:0];
    end
    return e;
  endfunction

  task automatic run_op(input string tag, input int d, input logic [31:0] xa, xb,
                        input logic xcin, xsub, xsgn, xsat,
                        input logic [31:0] e_sum, input logic e_co, e_ov, input int e_lat);
    int lat;
    @(negedge clk);
    a = xa; b = xb; cin = xcin; op_sub = xsub; op_signed = xsgn; op_sat = xsat;
    out_ready = 1'b1;
    in_valid_v = 3'b000;
    in_valid_v[d] = 1'b1;
    #1;
    check_val({tag, "_rdy"}, in_ready_v[d], 1'b1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      in_valid_v = 3'b000;
    end while (!out_valid_v[d] && lat < 20);
    check_val({tag, "_lat"}, lat, e_lat);
    check_val({tag, "_sum"}, rd_sum(d), e_sum);
    check_val({tag, "_cout"}, cout_v[d], e_co);
    check_val({tag, "_ovf"}, ovf_v[d], e_ov);
  endtask

  task automatic run_burst(input int n, input bit use_pat);
    int sent, got, occ, first_in, first_out, last_out;
    logic [31:0] ca, cb, p_sum;
    logic cc, csb, csg, cst, p_co, p_ov, fire_in, fire_out, prev_stall;
    bit   pat [5];
    exp_t e;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    sent = 0; got = 0; occ = 0; first_in = -1; first_out = -1; last_out = -1;
    prev_stall = 1'b0; p_sum = 32'd0; p_co = 1'b0; p_ov = 1'b0;
    ca = $urandom; cb = $urandom;
    cc = 1'($urandom_range(0, 1)); csb = 1'($urandom_range(0, 1));
    csg = 1'($urandom_range(0, 1)); cst = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 400 && got < n; cyc++) begin
      @(negedge clk);
      out_ready  = (use_pat && cyc < 15) ? pat[cyc % 5] : 1'b1;
      in_valid_v = (sent < n) ? 3'b001 : 3'b000;
      a = ca; b = cb; cin = cc; op_sub = csb; op_signed = csg; op_sat = cst;
      #1;
      if (prev_stall) begin
        check_val("stall_valid", out_valid_v[0], 1'b1);
        check_val("stall_sum", sum0, p_sum);
        check_val("stall_cout", cout_v[0], p_co);
        check_val("stall_ovf", ovf_v[0], p_ov);
      end
      check_val("burst_in_ready", in_ready_v[0], !((occ == 4) && !out_ready));
      fire_in  = in_valid_v[0] & in_ready_v[0];
      fire_out = out_valid_v[0] & out_ready;
      if (fire_out) begin
        if (sb.size() == 0) begin
          check_val("burst_spurious", 1'b1, 1'b0);
        end else begin
          e = sb.pop_front();
          check_val("burst_sum", sum0, e.s);
          check_val("burst_cout", cout_v[0], e.co);
          check_val("burst_ovf", ovf_v[0], e.ov);
        end
        got++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (fire_in) begin
        sb.push_back(ref_model(ca, cb, cc, csb, csg, cst));
        if (first_in < 0) first_in = cyc;
        sent++;
        ca = $urandom; cb = $urandom;
        cc = 1'($urandom_range(0, 1)); csb = 1'($urandom_range(0, 1));
        csg = 1'($urandom_range(0, 1)); cst = 1'($urandom_range(0, 1));
      end
      occ = occ + int'(fire_in) - int'(fire_out);
      prev_stall = out_valid_v[0] && !out_ready;
      p_sum = sum0; p_co = cout_v[0]; p_ov = ovf_v[0];
    end
    check_val("burst_count", got, n);
    if (!use_pat) begin
      check_val("tput_span", last_out - first_out, n - 1);
      check_val("tput_latency", first_out - first_in, 4);
    end
    in_valid_v = 3'b000;
  endtask

  initial begin
    bit stale;
    rst_n = 1'b0; in_valid_v = 3'b000; out_ready = 1'b0;
    a = 32'd0; b = 32'd0; cin = 1'b0; op_sub = 1'b0; op_signed = 1'b0; op_sat = 1'b0;
    repeat (2) @(negedge clk);
    check_val("reset_out_valid", out_valid_v, 3'b000);
    check_val("reset_sum", sum0, 32'd0);
    check_val("reset_cout", cout_v, 3'b000);
    check_val("reset_ovf", ovf_v, 3'b000);
    check_val("reset_in_ready", in_ready_v, 3'b000);
    rst_n = 1'b1;
    #1;
    check_val("release_in_ready_early", in_ready_v, 3'b000);
    @(negedge clk);
    check_val("release_in_ready", in_ready_v, 3'b111);

    run_op("uadd_wrap",   0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 4);
    run_op("uadd_sat",    0, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 4);
    run_op("usub_sat",    0, 32'h5, 32'h7, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 4);
    run_op("usub_wrap",   0, 32'h5, 32'h7, 1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 4);
    run_op("ssub_sat",    0, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 4);
    run_op("ssub_wrap",   0, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 4);
    run_op("sadd_sat",    0, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 4);
    run_op("uadd_cin",    0, 32'h1234_5678, 32'h0000_00FF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5778, 1'b0, 1'b0, 4);
    run_op("usub_borrow", 0, 32'd10, 32'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'd6, 1'b1, 1'b0, 4);

    run_burst(20, 1'b1);
    run_burst(8, 1'b0);

    // Three transactions parked in the pipe with the output stalled, then reset.
    @(negedge clk);
    out_ready = 1'b0; op_sub = 1'b0; op_signed = 1'b0; op_sat = 1'b0; cin = 1'b0; b = 32'h1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h10 + 32'(i);
      in_valid_v = 3'b001;
      @(negedge clk);
    end
    in_valid_v = 3'b000;
    repeat (4) @(negedge clk);
    check_val("rst_pre_valid", out_valid_v[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_async_valid", out_valid_v[0], 1'b0);
    check_val("rst_async_sum", sum0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_v[0]) stale = 1'b1;
    end
    check_val("rst_stale_output", stale, 1'b0);
    run_op("post_rst", 0, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h3, 1'b0, 1'b0, 4);

    run_op("w12_carry_seg", 1, 32'h0FF, 32'h001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 2);
    run_op("w12_cin_wrap",  1, 32'hFFF, 32'h000, 1'b1, 1'b0, 1'b0, 1'b0, 32'h000, 1'b1, 1'b1, 2);
    run_op("w12_sadd_sat",  1, 32'h7FF, 32'h001, 1'b0, 1'b0, 1'b1, 1'b1, 32'h7FF, 1'b0, 1'b1, 2);
    run_op("s1_add",        2, 32'h3, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'h7, 1'b0, 1'b0, 1);
    run_op("s1_uadd_sat",   2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
